// File: rtl/toy_loop_datapath.sv
// rtl/toy_loop_datapath.sv - loop-body datapath: indexed RAM walk, accumulate, publish sum
// Optional TOY_ACC_SATURATE_EN: accumulator saturates instead of wrapping.
module toy_loop_datapath #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fsm_stall,
  input  logic [ADDR_W:0]   loop_bound,
  input  logic              is_STATE_0,
  input  logic              is_STATE_1,
  input  logic              is_STATE_2,
  input  logic              is_STATE_3,
  input  logic              is_STATE_4,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic              mem_enable_a,
  input  logic [DATA_W-1:0] mem_readdata_a,
  output logic              BB_1_EXIT,
  output logic [ACC_W-1:0]  return_val
);

  localparam int IW = ADDR_W + 1;

  logic [IW-1:0]     idx;
  logic [IW-1:0]     bound_q;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] mem_q;
  logic [ACC_W-1:0]  acc_sum;
  logic              idx_last;

`ifdef TOY_ACC_SATURATE_EN
  logic [ACC_W:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_W+1)'(mem_q);
    acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_sum = acc + ACC_W'(mem_q);
  end
`endif

  // One extra bit keeps idx+1 from wrapping before the compare.
  assign idx_last      = ({1'b0, idx} + 1'b1) >= {1'b0, bound_q};
  assign mem_address_a = idx[ADDR_W-1:0];
  assign mem_enable_a  = is_STATE_1 & ~fsm_stall & ~reset;
  assign BB_1_EXIT     = is_STATE_3 & idx_last & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      acc        <= '0;
      mem_q      <= '0;
      bound_q    <= IW'(1);
      return_val <= '0;
    end else if (!fsm_stall) begin
      if (is_STATE_0) begin
        if (start) begin
          idx     <= '0;
          acc     <= '0;
          bound_q <= (loop_bound == '0) ? IW'(1) : loop_bound;
        end
      end else if (is_STATE_1) begin
        // Read issued combinationally; nothing to register yet.
      end else if (is_STATE_2) begin
        mem_q <= mem_readdata_a;
      end else if (is_STATE_3) begin
        acc <= acc_sum;
        idx <= idx + 1'b1;
      end else if (is_STATE_4) begin
        return_val <= acc;
      end
    end
  end

endmodule

// File: tb/tb_toy_loop_datapath.sv
// tb/tb_toy_loop_datapath.sv - scoreboard bench driving controller strobes directly
module tb_toy_loop_datapath;

  logic        clk = 1'b0;
  logic        reset, start, fsm_stall;
  logic [8:0]  loop_bound;
  logic        s0, s1, s2, s3, s4;
  logic [7:0]  mem_address_a;
  logic        mem_enable_a;
  logic [15:0] mem_readdata_a;
  logic        bb_exit;
  logic [31:0] return_val;

  logic [7:0]  addr8;
  logic        en8, exit8;
  logic [7:0]  rd8;
  logic [7:0]  ret8;

  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  bit exp_exit_q[$];
  int exp_ret_q[$];
  int exp_hold = 0;
  bit ret_due = 1'b0;

`ifdef TOY_ACC_SATURATE_EN
  localparam int EXP8 = 255;
`else
  localparam int EXP8 = 88;
`endif

  always #5 clk = ~clk;

  toy_loop_datapath dut (
    .clk(clk), .reset(reset), .start(start), .fsm_stall(fsm_stall),
    .loop_bound(loop_bound),
    .is_STATE_0(s0), .is_STATE_1(s1), .is_STATE_2(s2), .is_STATE_3(s3), .is_STATE_4(s4),
    .mem_address_a(mem_address_a), .mem_enable_a(mem_enable_a),
    .mem_readdata_a(mem_readdata_a), .BB_1_EXIT(bb_exit), .return_val(return_val)
  );

  toy_loop_datapath #(.ADDR_W(8), .DATA_W(8), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .fsm_stall(fsm_stall),
    .loop_bound(loop_bound),
    .is_STATE_0(s0), .is_STATE_1(s1), .is_STATE_2(s2), .is_STATE_3(s3), .is_STATE_4(s4),
    .mem_address_a(addr8), .mem_enable_a(en8),
    .mem_readdata_a(rd8), .BB_1_EXIT(exit8), .return_val(ret8)
  );

  assign rd8 = 8'd200;

  always @(posedge clk) begin
    if (reset) mem_readdata_a <= '0;
    else if (mem_enable_a) mem_readdata_a <= mem[mem_address_a];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int st, input bit stall);
    s0 = (st == 0); s1 = (st == 1); s2 = (st == 2); s3 = (st == 3); s4 = (st == 4);
    fsm_stall = stall;
    tick();
  endtask

  task automatic run(input int bound, input int n, input int ret, input int stall_it,
                     input int new_bound);
    loop_bound = 9'(bound);
    start = 1'b1;
    drive(0, 1'b0);
    start = 1'b0;
    loop_bound = 9'(new_bound);
    for (int it = 0; it < n; it++) begin
      exp_addr_q.push_back(it);
      exp_exit_q.push_back(it == n - 1);
      for (int st = 1; st <= 3; st++) begin
        if (it == stall_it) repeat (3) drive(st, 1'b1);
        drive(st, 1'b0);
      end
    end
    exp_ret_q.push_back(ret);
    drive(4, 1'b0);
    drive(0, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, exit or result.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_enable", mem_enable_a, 0);
        check("reset_exit", bb_exit, 0);
      end else begin
        if (ret_due) begin
          ret_due = 1'b0;
          if (exp_ret_q.size() == 0) check("ret_extra", 1, 0);
          else begin
            exp_hold = exp_ret_q.pop_front();
            check("return_val", return_val, exp_hold);
          end
        end else begin
          check("ret_hold", return_val, exp_hold);
        end
        if (mem_enable_a) begin
          if (exp_addr_q.size() == 0) check("enable_extra", 1, 0);
          else check("mem_address", mem_address_a, exp_addr_q.pop_front());
        end
        if (s3) begin
          if (exp_exit_q.size() == 0) check("exit_extra", 1, 0);
          else begin
            check("bb_exit", bb_exit, exp_exit_q[0]);
            if (!fsm_stall) void'(exp_exit_q.pop_front());
          end
        end else begin
          check("exit_idle", bb_exit, 0);
        end
        if (s4 && !fsm_stall) ret_due = 1'b1;
      end
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'(k + 1);
    reset = 1'b1; start = 1'b0; fsm_stall = 1'b0; loop_bound = '0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
    tick();
    tick();
    check("rst_return_val", return_val, 0);
    check("rst_idx", dut.idx, 0);
    check("rst_acc", dut.acc, 0);
    check("rst_bound_q", dut.bound_q, 1);
    reset = 1'b0;
    drive(0, 1'b0);

    run(4, 4, 10, -1, 4);
    run(0, 1, 1, -1, 0);
    run(4, 4, 10, 1, 4);
    run(3, 3, 6, -1, 3);
    check("sat_wrap_acc8", ret8, EXP8);

    // Reset lands in STATE_3 of the second iteration.
    loop_bound = 9'd4;
    start = 1'b1;
    drive(0, 1'b0);
    start = 1'b0;
    exp_addr_q.push_back(0);
    exp_exit_q.push_back(1'b0);
    drive(1, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
    exp_addr_q.push_back(1);
    drive(1, 1'b0); drive(2, 1'b0);
    reset = 1'b1;
    drive(3, 1'b0);
    reset = 1'b0;
    exp_hold = 0;
    check("midrst_idx", dut.idx, 0);
    check("midrst_acc", dut.acc, 0);
    check("midrst_mem_q", dut.mem_q, 0);
    check("midrst_return_val", return_val, 0);
    drive(0, 1'b0);
    run(2, 2, 3, -1, 2);

    run(4, 4, 10, -1, 1);
    run(2, 2, 3, -1, 2);

    drive(0, 1'b0);
    drive(0, 1'b0);
    check("addr_q_left", exp_addr_q.size(), 0);
    check("exit_q_left", exp_exit_q.size(), 0);
    check("ret_q_left", exp_ret_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
